// File: rtl/ex_stage_pkg.sv
// Shared widths, funct codes, divider state encoding and the decoded id->ex bundle layout.
// The MULT_ITER_EN macro selects the iterative multiplier in ex_stage/div_iter.
package ex_stage_pkg;

  localparam int StallBus     = 6;
  localparam int ID_TO_EX_WD  = 227;
  localparam int EX_TO_ID_WD  = 104;
  localparam int EX_TO_MEM_WD = 142;

  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  typedef struct packed {
    logic        hi_read;
    logic        lo_read;
    logic        hi_write;
    logic        lo_write;
    logic [31:0] hi_out_file;
    logic [31:0] lo_out_file;
    logic [31:0] id_pc;
    logic [31:0] inst;
    logic [11:0] alu_op;
    logic [2:0]  sel_alu_src1;
    logic [3:0]  sel_alu_src2;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
  } id_to_ex_t;

  function automatic logic [31:0] neg_if(input logic n, input logic [31:0] v);
    return n ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_stage_div_iter.sv
// Iterative 32-step restoring divider (and shift-add multiplier when MULT_ITER_EN is defined).
// Works on magnitudes; signs are restored combinationally while in DONE.
module div_iter
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        start,
  input  logic        signed_op,
  input  logic        mul_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  div_state_e  r_state;
  logic [5:0]  r_cnt;
  logic [31:0] r_hi, r_lo, r_b, r_a;
  logic        r_mul, r_neg_q, r_neg_r, r_bzero;

  logic [31:0] w_abs_a, w_abs_b, w_diff;
  logic [32:0] w_shift;
  logic [63:0] w_prod;

  assign w_abs_a = neg_if(signed_op & a[31], a);
  assign w_abs_b = neg_if(signed_op & b[31], b);
  assign w_shift = {r_hi, r_lo[31]};
  assign w_diff  = w_shift[31:0] - r_b;

`ifdef MULT_ITER_EN
  logic [32:0] w_sum;
  assign w_sum = {1'b0, r_hi} + {1'b0, r_b};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_b     <= '0;
      r_a     <= '0;
      r_mul   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_bzero <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_BUSY;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= w_abs_a;
            r_b     <= w_abs_b;
            r_a     <= a;
            r_mul   <= mul_op;
            r_neg_q <= signed_op & (a[31] ^ b[31]);
            r_neg_r <= signed_op & a[31];
            r_bzero <= ~mul_op & (b == 32'd0);
          end
        end
        ST_BUSY: begin
          if (r_mul) begin
`ifdef MULT_ITER_EN
            // {carry, hi, lo} >> 1, consuming one multiplier bit from lo
            {r_hi, r_lo} <= {(r_lo[0] ? w_sum : {1'b0, r_hi}), r_lo[31:1]};
`endif
          end else if (w_shift >= {1'b0, r_b}) begin
            r_hi <= w_diff;
            r_lo <= {r_lo[30:0], 1'b1};
          end else begin
            r_hi <= w_shift[31:0];
            r_lo <= {r_lo[30:0], 1'b0};
          end
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd31) r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (!hold) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy   = (r_state == ST_BUSY);
  assign done   = (r_state == ST_DONE);
  assign w_prod = r_neg_q ? (~{r_hi, r_lo} + 64'd1) : {r_hi, r_lo};

  always_comb begin
    if (r_mul) begin
      hi = w_prod[63:32];
      lo = w_prod[31:0];
    end else if (r_bzero) begin
      hi = r_a;
      lo = 32'hFFFF_FFFF;
    end else begin
      hi = neg_if(r_neg_r, r_hi);
      lo = neg_if(r_neg_q, r_lo);
    end
  end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: input register, one-hot ALU, data-SRAM request, HI/LO via div_iter.
// Define MULT_ITER_EN to route mult/multu through the iterative 33-cycle datapath.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [StallBus-1:0]     stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [EX_TO_ID_WD-1:0]  ex_to_id_bus,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  output logic                    stallreq_for_ex
);

  id_to_ex_t r_in;

  always_ff @(posedge clk) begin
    if (rst)                        r_in <= '0;
    else if (stall[2] && !stall[3]) r_in <= '0;
    else if (!stall[2])             r_in <= id_to_ex_t'(id_to_ex_bus);
  end

  logic [31:0] w_src1, w_src2, w_sra, w_alu, w_result;
  logic [11:0] w_op;
  logic [4:0]  w_shamt;

  assign w_src1 = ({32{r_in.sel_alu_src1[0]}} & r_in.rdata1)
                | ({32{r_in.sel_alu_src1[1]}} & r_in.id_pc)
                | ({32{r_in.sel_alu_src1[2]}} & {27'b0, r_in.inst[10:6]});
  assign w_src2 = ({32{r_in.sel_alu_src2[0]}} & r_in.rdata2)
                | ({32{r_in.sel_alu_src2[1]}} & {{16{r_in.inst[15]}}, r_in.inst[15:0]})
                | ({32{r_in.sel_alu_src2[2]}} & 32'd8)
                | ({32{r_in.sel_alu_src2[3]}} & {16'b0, r_in.inst[15:0]});

  assign w_op    = r_in.alu_op;
  assign w_shamt = w_src1[4:0];
  assign w_sra   = $signed(w_src2) >>> w_shamt;

  assign w_alu = ({32{w_op[11]}} & (w_src1 + w_src2))
               | ({32{w_op[10]}} & (w_src1 - w_src2))
               | ({32{w_op[9]}}  & {31'b0, $signed(w_src1) < $signed(w_src2)})
               | ({32{w_op[8]}}  & {31'b0, w_src1 < w_src2})
               | ({32{w_op[7]}}  & (w_src1 & w_src2))
               | ({32{w_op[6]}}  & ~(w_src1 | w_src2))
               | ({32{w_op[5]}}  & (w_src1 | w_src2))
               | ({32{w_op[4]}}  & (w_src1 ^ w_src2))
               | ({32{w_op[3]}}  & (w_src2 << w_shamt))
               | ({32{w_op[2]}}  & (w_src2 >> w_shamt))
               | ({32{w_op[1]}}  & w_sra)
               | ({32{w_op[0]}}  & {w_src2[15:0], 16'b0});

  assign w_result = r_in.hi_read ? r_in.hi_out_file :
                    r_in.lo_read ? r_in.lo_out_file : w_alu;

  logic [5:0]  w_funct;
  logic        w_op0, w_is_div, w_is_mul, w_signed, w_mc, w_mul_fsm;
  logic        w_div_busy, w_div_done;
  logic [31:0] w_div_hi, w_div_lo;

  assign w_funct  = r_in.inst[5:0];
  assign w_op0    = (r_in.inst[31:26] == 6'd0);
  assign w_is_div = w_op0 & ((w_funct == FUNCT_DIV) | (w_funct == FUNCT_DIVU));
  assign w_is_mul = w_op0 & ((w_funct == FUNCT_MULT) | (w_funct == FUNCT_MULTU));
  assign w_signed = ~w_funct[0];

`ifdef MULT_ITER_EN
  assign w_mc      = w_is_div | w_is_mul;
  assign w_mul_fsm = w_is_mul;
`else
  assign w_mc      = w_is_div;
  assign w_mul_fsm = 1'b0;
  logic [63:0] w_ma, w_mb, w_prod;
  // Sign-extending to 64 bits makes one unsigned multiply serve both mult and multu
  assign w_ma   = {{32{w_signed & r_in.rdata1[31]}}, r_in.rdata1};
  assign w_mb   = {{32{w_signed & r_in.rdata2[31]}}, r_in.rdata2};
  assign w_prod = w_ma * w_mb;
`endif

  div_iter u_div_iter (
    .clk       (clk),
    .rst       (rst),
    .hold      (stall[3]),
    .start     (w_mc),
    .signed_op (w_signed),
    .mul_op    (w_mul_fsm),
    .a         (r_in.rdata1),
    .b         (r_in.rdata2),
    .busy      (w_div_busy),
    .done      (w_div_done),
    .hi        (w_div_hi),
    .lo        (w_div_lo)
  );

  assign stallreq_for_ex = w_mc & ~w_div_done;

  logic        w_hi_we, w_lo_we;
  logic [31:0] w_hi_i, w_lo_i;

  always_comb begin
    w_hi_we = r_in.hi_write;
    w_lo_we = r_in.lo_write;
    w_hi_i  = r_in.rdata1;
    w_lo_i  = r_in.rdata1;
    if (w_mc) begin
      w_hi_we = w_div_done;
      w_lo_we = w_div_done;
      w_hi_i  = w_div_hi;
      w_lo_i  = w_div_lo;
    end
`ifndef MULT_ITER_EN
    else if (w_is_mul) begin
      w_hi_we = 1'b1;
      w_lo_we = 1'b1;
      w_hi_i  = w_prod[63:32];
      w_lo_i  = w_prod[31:0];
    end
`endif
  end

  logic w_unused;
  assign w_unused = ^{r_in.inst[25:16], stall[5:4], stall[1:0], w_div_busy};

  assign ex_to_mem_bus = {w_hi_we, w_hi_i, w_lo_we, w_lo_i, r_in.id_pc, r_in.data_ram_en,
                          r_in.data_ram_wen, r_in.sel_rf_res, r_in.rf_we, r_in.rf_waddr, w_result};
  assign ex_to_id_bus  = {w_hi_we, w_hi_i, w_lo_we, w_lo_i, r_in.rf_we, r_in.rf_waddr, w_result};

  assign data_sram_en    = r_in.data_ram_en;
  assign data_sram_wen   = r_in.data_ram_wen;
  assign data_sram_addr  = w_result;
  assign data_sram_wdata = r_in.rdata2;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, memory request, HI/LO writes, divider/multiplier timing, stalls.
// Expected multiply latency follows MULT_ITER_EN.
module tb_ex_stage;
  import ex_stage_pkg::*;

`ifdef MULT_ITER_EN
  localparam int MulCycles = 33;
`else
  localparam int MulCycles = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] tb_stall = 6'd0;
  logic [5:0] stall;
  id_to_ex_t req;
  logic [226:0] id_to_ex_bus;
  logic [141:0] ex_to_mem_bus;
  logic [103:0] ex_to_id_bus;
  logic data_sram_en, stallreq_for_ex;
  logic [3:0] data_sram_wen;
  logic [31:0] data_sram_addr, data_sram_wdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Stall controller model: an EX stall request freezes stages 0..3
  assign stall = stallreq_for_ex ? 6'b001111 : tb_stall;
  assign id_to_ex_bus = req;

  ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .id_to_ex_bus(id_to_ex_bus),
    .ex_to_mem_bus(ex_to_mem_bus), .ex_to_id_bus(ex_to_id_bus),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .stallreq_for_ex(stallreq_for_ex)
  );

  logic [31:0] m_result, m_pc, m_lo_i, m_hi_i, d_result, d_lo_i, d_hi_i;
  logic [4:0]  m_waddr, d_waddr;
  logic [3:0]  m_wen;
  logic        m_rf_we, m_sel, m_en, m_lo_we, m_hi_we, d_rf_we, d_lo_we, d_hi_we;
  assign {m_hi_we, m_hi_i, m_lo_we, m_lo_i, m_pc, m_en, m_wen, m_sel, m_rf_we, m_waddr, m_result} = ex_to_mem_bus;
  assign {d_hi_we, d_hi_i, d_lo_we, d_lo_i, d_rf_we, d_waddr, d_result} = ex_to_id_bus;

  function automatic id_to_ex_t mk_alu(input logic [11:0] op, input logic [2:0] s1, input logic [3:0] s2,
                                       input logic [31:0] inst, input logic [31:0] r1, input logic [31:0] r2);
    id_to_ex_t v = '0;
    v.alu_op = op; v.sel_alu_src1 = s1; v.sel_alu_src2 = s2; v.inst = inst;
    v.rdata1 = r1; v.rdata2 = r2; v.rf_we = 1'b1; v.rf_waddr = 5'd3; v.id_pc = 32'hBFC0_0000;
    return v;
  endfunction

  function automatic id_to_ex_t mk_md(input logic [5:0] funct, input logic [31:0] a, input logic [31:0] b);
    id_to_ex_t v = '0;
    v.inst = {26'b0, funct}; v.rdata1 = a; v.rdata2 = b;
    return v;
  endfunction

  id_to_ex_t addiu_v;
  initial addiu_v = mk_alu(12'h800, 3'b001, 4'b0010, 32'h2422_FFFF, 32'd5, 32'd0);

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Counts cycles with the stall request high (bounded), noting any early HI/LO write enable
  task automatic wait_stall(output int n, output bit we_early);
    n = 0; we_early = 1'b0;
    while (stallreq_for_ex === 1'b1 && n < 100) begin
      if (m_hi_we || m_lo_we) we_early = 1'b1;
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = addiu_v;
    tick(); tick();
    n_cmp++; if (ex_to_mem_bus !== '0) begin n_bad++; $display("FAIL reset_mem_bus: got %h want 0", ex_to_mem_bus); end
    n_cmp++; if (ex_to_id_bus !== '0) begin n_bad++; $display("FAIL reset_id_bus: got %h want 0", ex_to_id_bus); end
    n_cmp++; if ({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata} !== '0) begin
      n_bad++; $display("FAIL reset_sram: got en=%b wen=%b addr=%h wdata=%h want 0", data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata); end
    n_cmp++; if (stallreq_for_ex !== 1'b0) begin n_bad++; $display("FAIL reset_stallreq: got %b want 0", stallreq_for_ex); end
    rst = 1'b0;
  endtask

  task automatic test_mem();
    req = addiu_v;
    tick();
    n_cmp++; if (m_result !== 32'd4) begin n_bad++; $display("FAIL addiu_result: got %h want 4", m_result); end
    n_cmp++; if (m_rf_we !== 1'b1 || d_rf_we !== 1'b1) begin n_bad++; $display("FAIL addiu_rf_we: got %b/%b want 1", m_rf_we, d_rf_we); end
    n_cmp++; if (data_sram_en !== 1'b0) begin n_bad++; $display("FAIL addiu_sram_en: got %b want 0", data_sram_en); end
    req = mk_alu(12'h800, 3'b001, 4'b0010, 32'h8C22_0008, 32'h0000_1000, 32'd0);
    req.data_ram_en = 1'b1; req.sel_rf_res = 1'b1;
    tick();
    n_cmp++; if (data_sram_en !== 1'b1 || data_sram_wen !== 4'b0000) begin
      n_bad++; $display("FAIL lw_en_wen: got en=%b wen=%b want en=1 wen=0000", data_sram_en, data_sram_wen); end
    n_cmp++; if (data_sram_addr !== 32'h0000_1008) begin n_bad++; $display("FAIL lw_addr: got %h want 00001008", data_sram_addr); end
    n_cmp++; if (m_sel !== 1'b1 || m_en !== 1'b1) begin n_bad++; $display("FAIL lw_mem_bus: got sel=%b en=%b want 1/1", m_sel, m_en); end
    req = mk_alu(12'h800, 3'b001, 4'b0010, 32'hAC22_FFFC, 32'h0000_2000, 32'hDEAD_BEEF);
    req.data_ram_en = 1'b1; req.data_ram_wen = 4'b1111; req.rf_we = 1'b0;
    tick();
    n_cmp++; if (data_sram_wen !== 4'b1111 || m_wen !== 4'b1111) begin n_bad++; $display("FAIL sw_wen: got %b/%b want 1111", data_sram_wen, m_wen); end
    n_cmp++; if (data_sram_addr !== 32'h0000_1FFC) begin n_bad++; $display("FAIL sw_addr: got %h want 00001ffc", data_sram_addr); end
    n_cmp++; if (data_sram_wdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL sw_wdata: got %h want deadbeef", data_sram_wdata); end
  endtask

  typedef struct {
    logic [11:0] op; logic [2:0] s1; logic [3:0] s2;
    logic [31:0] inst, r1, r2, exp;
  } alu_vec_t;

  task automatic test_alu();
    alu_vec_t v[$];
    v.push_back('{12'h400, 3'b001, 4'b0001, 32'h0000_0023, 32'd3,          32'd5,          32'hFFFF_FFFE});
    v.push_back('{12'h200, 3'b001, 4'b0001, 32'h0000_002A, 32'hFFFF_FFFF, 32'd1,          32'd1});
    v.push_back('{12'h100, 3'b001, 4'b0001, 32'h0000_002B, 32'hFFFF_FFFF, 32'd1,          32'd0});
    v.push_back('{12'h080, 3'b001, 4'b0001, 32'h0000_0024, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000});
    v.push_back('{12'h040, 3'b001, 4'b0001, 32'h0000_0027, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0000_0F0F});
    v.push_back('{12'h020, 3'b001, 4'b0001, 32'h0000_0025, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678});
    v.push_back('{12'h010, 3'b001, 4'b0001, 32'h0000_0026, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F});
    v.push_back('{12'h008, 3'b100, 4'b0001, 32'h0000_0100, 32'hFFFF_FFFF, 32'h0000_000F, 32'h0000_00F0});
    v.push_back('{12'h004, 3'b100, 4'b0001, 32'h0000_0102, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0800_0000});
    v.push_back('{12'h002, 3'b100, 4'b0001, 32'h0000_0103, 32'hFFFF_FFFF, 32'h8000_0000, 32'hF800_0000});
    v.push_back('{12'h001, 3'b000, 4'b1000, 32'h3C01_ABCD, 32'h1111_1111, 32'd0,          32'hABCD_0000});
    v.push_back('{12'h800, 3'b010, 4'b0100, 32'h0C00_0000, 32'h1111_1111, 32'd0,          32'hBFC0_0008});
    v.push_back('{12'h020, 3'b001, 4'b1000, 32'h3421_8001, 32'h0001_0000, 32'd0,          32'h0001_8001});
    v.push_back('{12'h200, 3'b001, 4'b0010, 32'h2821_FFFF, 32'hFFFF_FFFE, 32'd0,          32'd1});
    for (int i = 0; i < v.size(); i++) begin
      req = mk_alu(v[i].op, v[i].s1, v[i].s2, v[i].inst, v[i].r1, v[i].r2);
      tick();
      n_cmp++; if (m_result !== v[i].exp || d_result !== v[i].exp) begin
        n_bad++; $display("FAIL alu_vec%0d: got mem=%h id=%h want %h", i, m_result, d_result, v[i].exp); end
    end
    n_cmp++; if (m_pc !== 32'hBFC0_0000) begin n_bad++; $display("FAIL ex_pc: got %h want bfc00000", m_pc); end
  endtask

  task automatic test_hilo();
    req = mk_alu(12'h800, 3'b001, 4'b0001, 32'h0000_0010, 32'd1, 32'd2);
    req.hi_read = 1'b1; req.lo_read = 1'b1; req.hi_out_file = 32'h1111_2222; req.lo_out_file = 32'h3333_4444;
    tick();
    n_cmp++; if (m_result !== 32'h1111_2222) begin n_bad++; $display("FAIL mfhi_priority: got %h want 11112222", m_result); end
    req.hi_read = 1'b0;
    tick();
    n_cmp++; if (m_result !== 32'h3333_4444) begin n_bad++; $display("FAIL mflo: got %h want 33334444", m_result); end
    req = mk_md(6'h11, 32'h0000_0055, 32'd0); req.hi_write = 1'b1;
    tick();
    n_cmp++; if (m_hi_we !== 1'b1 || m_lo_we !== 1'b0 || m_hi_i !== 32'h55) begin
      n_bad++; $display("FAIL mthi: got hi_we=%b lo_we=%b hi_i=%h want 1 0 00000055", m_hi_we, m_lo_we, m_hi_i); end
    n_cmp++; if (d_hi_we !== 1'b1 || d_hi_i !== 32'h55) begin n_bad++; $display("FAIL mthi_id_bus: got %b %h want 1 00000055", d_hi_we, d_hi_i); end
  endtask

  task automatic test_div();
    int n; bit early;
    req = mk_md(FUNCT_DIV, 32'hFFFF_FFF9, 32'd2);
    tick();
    wait_stall(n, early);
    n_cmp++; if (n !== 33) begin n_bad++; $display("FAIL div_stall_cycles: got %0d want 33", n); end
    n_cmp++; if (early !== 1'b0) begin n_bad++; $display("FAIL div_early_we: got %b want 0", early); end
    n_cmp++; if (m_lo_i !== 32'hFFFF_FFFD || m_hi_i !== 32'hFFFF_FFFF) begin
      n_bad++; $display("FAIL div_result: got lo=%h hi=%h want fffffffd ffffffff", m_lo_i, m_hi_i); end
    n_cmp++; if (m_hi_we !== 1'b1 || m_lo_we !== 1'b1 || d_hi_we !== 1'b1 || d_lo_we !== 1'b1) begin
      n_bad++; $display("FAIL div_we: got %b%b/%b%b want 11/11", m_hi_we, m_lo_we, d_hi_we, d_lo_we); end
    tb_stall = 6'b001111; req = addiu_v;
    tick(); tick();
    n_cmp++; if (m_lo_we !== 1'b1 || m_lo_i !== 32'hFFFF_FFFD || stallreq_for_ex !== 1'b0) begin
      n_bad++; $display("FAIL div_done_hold: got lo_we=%b lo=%h stallreq=%b want 1 fffffffd 0", m_lo_we, m_lo_i, stallreq_for_ex); end
    tb_stall = 6'd0;
    tick();
    n_cmp++; if (m_result !== 32'd4 || m_hi_we !== 1'b0 || stallreq_for_ex !== 1'b0) begin
      n_bad++; $display("FAIL div_after: got res=%h hi_we=%b stallreq=%b want 4 0 0", m_result, m_hi_we, stallreq_for_ex); end
  endtask

  task automatic test_divu_reset();
    int n; bit early;
    req = mk_md(FUNCT_DIVU, 32'd10, 32'd0);
    tick();
    wait_stall(n, early);
    n_cmp++; if (n !== 33) begin n_bad++; $display("FAIL divu0_cycles: got %0d want 33", n); end
    n_cmp++; if (m_lo_i !== 32'hFFFF_FFFF || m_hi_i !== 32'd10) begin
      n_bad++; $display("FAIL divu0_result: got lo=%h hi=%h want ffffffff 0000000a", m_lo_i, m_hi_i); end
    req = mk_md(FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    tick();
    repeat (10) tick();
    rst = 1'b1;
    tick();
    n_cmp++; if (stallreq_for_ex !== 1'b0 || ex_to_mem_bus !== '0) begin
      n_bad++; $display("FAIL mid_div_reset: got stallreq=%b bus=%h want 0 0", stallreq_for_ex, ex_to_mem_bus); end
    rst = 1'b0;
    tick();
    wait_stall(n, early);
    n_cmp++; if (n !== 33) begin n_bad++; $display("FAIL div_after_reset_cycles: got %0d want 33", n); end
    n_cmp++; if (m_lo_i !== 32'h8000_0000 || m_hi_i !== 32'd0 || m_lo_we !== 1'b1) begin
      n_bad++; $display("FAIL div_minint: got lo=%h hi=%h lo_we=%b want 80000000 0 1", m_lo_i, m_hi_i, m_lo_we); end
  endtask

  task automatic test_mult();
    int n; bit early;
    req = mk_md(FUNCT_MULT, 32'hFFFF_FFFF, 32'd2);
    tick();
    wait_stall(n, early);
    n_cmp++; if (n !== MulCycles) begin n_bad++; $display("FAIL mult_cycles: got %0d want %0d", n, MulCycles); end
    n_cmp++; if (m_hi_i !== 32'hFFFF_FFFF || m_lo_i !== 32'hFFFF_FFFE || m_hi_we !== 1'b1 || m_lo_we !== 1'b1) begin
      n_bad++; $display("FAIL mult_result: got hi=%h lo=%h we=%b%b want ffffffff fffffffe 11", m_hi_i, m_lo_i, m_hi_we, m_lo_we); end
    req = mk_md(FUNCT_MULTU, 32'hFFFF_FFFF, 32'd2);
    tick();
    wait_stall(n, early);
    n_cmp++; if (n !== MulCycles || early !== 1'b0) begin n_bad++; $display("FAIL multu_cycles: got %0d early=%b want %0d 0", n, early, MulCycles); end
    n_cmp++; if (m_hi_i !== 32'd1 || m_lo_i !== 32'hFFFF_FFFE) begin
      n_bad++; $display("FAIL multu_result: got hi=%h lo=%h want 00000001 fffffffe", m_hi_i, m_lo_i); end
  endtask

  task automatic test_back_to_back();
    int n; bit early;
    req = mk_md(FUNCT_DIVU, 32'd100, 32'd7);
    tick();
    wait_stall(n, early);
    n_cmp++; if (n !== 33 || m_lo_i !== 32'd14 || m_hi_i !== 32'd2) begin
      n_bad++; $display("FAIL b2b_first: got n=%0d lo=%h hi=%h want 33 e 2", n, m_lo_i, m_hi_i); end
    req = mk_md(FUNCT_DIVU, 32'hFFFF_FFFF, 32'd16);
    tick();
    wait_stall(n, early);
    n_cmp++; if (n !== 33 || m_lo_i !== 32'h0FFF_FFFF || m_hi_i !== 32'd15) begin
      n_bad++; $display("FAIL b2b_second: got n=%0d lo=%h hi=%h want 33 0fffffff f", n, m_lo_i, m_hi_i); end
    req = addiu_v;
    tick();
    n_cmp++; if (m_result !== 32'd4 || stallreq_for_ex !== 1'b0) begin
      n_bad++; $display("FAIL b2b_alu: got res=%h stallreq=%b want 4 0", m_result, stallreq_for_ex); end
  endtask

  task automatic test_bubble();
    req = addiu_v;
    tick();
    tb_stall = 6'b001100;
    req = mk_alu(12'h001, 3'b000, 4'b1000, 32'h3C01_ABCD, 32'd0, 32'd0);
    tick();
    n_cmp++; if (m_result !== 32'd4) begin n_bad++; $display("FAIL stall_hold: got %h want 4", m_result); end
    tb_stall = 6'b000100;
    tick();
    n_cmp++; if (ex_to_mem_bus !== '0 || ex_to_id_bus !== '0) begin
      n_bad++; $display("FAIL bubble_buses: got mem=%h id=%h want 0", ex_to_mem_bus, ex_to_id_bus); end
    n_cmp++; if ({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, stallreq_for_ex} !== '0) begin
      n_bad++; $display("FAIL bubble_sram: got en=%b wen=%b addr=%h stallreq=%b want 0", data_sram_en, data_sram_wen, data_sram_addr, stallreq_for_ex); end
    tb_stall = 6'd0;
  endtask

  initial begin
    test_reset();
    test_mem();
    test_alu();
    test_hilo();
    test_div();
    test_divu_reset();
    test_mult();
    test_back_to_back();
    test_bubble();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
